// File: rtl/i2c_clk_gen.sv
// I2C SCL bit-clock generator: four-quarter divider with slave clock-stretch hold and timeout.
// Define I2C_SCL_SYNC_EN to pass scl_in_i through a 2-flop synchronizer before the stretch check.
module i2c_clk_gen #(
   parameter int DIVIDER         = 6500,
   parameter int CNT_W           = 15,
   parameter int CHK_OFS         = 2,
   parameter int TO_W            = 16,
   parameter int STRETCH_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena_i,
   input  logic       scl_in_i,
   input  logic       clear_err_i,
   output logic       scl_oe_o,
   output logic       data_clk_o,
   output logic [1:0] quarter_o,
   output logic       data_tick_o,
   output logic       stretching_o,
   output logic       timeout_err_o,
   output logic       busy_o
);

   localparam logic [CNT_W-1:0] Q1   = CNT_W'(DIVIDER);
   localparam logic [CNT_W-1:0] Q2   = CNT_W'(2 * DIVIDER);
   localparam logic [CNT_W-1:0] Q3   = CNT_W'(3 * DIVIDER);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(4 * DIVIDER - 1);
   localparam logic [CNT_W-1:0] CHK  = CNT_W'(2 * DIVIDER + CHK_OFS);
   localparam logic [TO_W-1:0]  TMO  = TO_W'(STRETCH_TIMEOUT);

   logic             scl_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]  tcnt_q, tcnt_d;
   logic             busy_q, busy_d;
   logic             abandon_q, abandon_d;
   logic             scl_oe_q, scl_oe_d;
   logic             data_clk_q, data_clk_d;
   logic [1:0]       quarter_q, quarter_d;
   logic             tick_q, tick_d;
   logic             stretch_q, stretch_d;
   logic             terr_q, terr_d;
   logic             at_chk;
   logic             tmo_set;

`ifdef I2C_SCL_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], scl_in_i};
   end

   assign scl_s = sync_q[1];
`else
   assign scl_s = scl_in_i;
`endif

   assign at_chk = busy_q && (cnt_q == CHK) && !scl_s && !abandon_q;

   always_comb begin
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      tcnt_d    = tcnt_q;
      abandon_d = abandon_q;
      stretch_d = 1'b0;
      tmo_set   = 1'b0;
      if (!busy_q) begin
         cnt_d  = '0;
         busy_d = ena_i;
      end else if (at_chk && (tcnt_q < TMO)) begin
         stretch_d = 1'b1;
         tcnt_d    = tcnt_q + 1'b1;
      end else begin
         // Timeout abandons the stretch until the next wrap re-arms it.
         if (at_chk) begin
            tmo_set   = 1'b1;
            abandon_d = 1'b1;
         end
         if (cnt_q == LAST) begin
            cnt_d     = '0;
            busy_d    = ena_i;
            tcnt_d    = '0;
            abandon_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      scl_oe_d   = busy_d && (cnt_d < Q2);
      data_clk_d = busy_d && (cnt_d >= Q1) && (cnt_d < Q3);
      tick_d     = busy_d && (cnt_d == Q1);
      quarter_d  = 2'd0;
      if (busy_d) begin
         if (cnt_d < Q1)      quarter_d = 2'd0;
         else if (cnt_d < Q2) quarter_d = 2'd1;
         else if (cnt_d < Q3) quarter_d = 2'd2;
         else                 quarter_d = 2'd3;
      end
      terr_d = terr_q;
      if (tmo_set)          terr_d = 1'b1;
      else if (clear_err_i) terr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         tcnt_q     <= '0;
         busy_q     <= 1'b0;
         abandon_q  <= 1'b0;
         scl_oe_q   <= 1'b0;
         data_clk_q <= 1'b0;
         quarter_q  <= 2'd0;
         tick_q     <= 1'b0;
         stretch_q  <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         busy_q     <= busy_d;
         abandon_q  <= abandon_d;
         scl_oe_q   <= scl_oe_d;
         data_clk_q <= data_clk_d;
         quarter_q  <= quarter_d;
         tick_q     <= tick_d;
         stretch_q  <= stretch_d;
         terr_q     <= terr_d;
      end
   end

   assign scl_oe_o      = scl_oe_q;
   assign data_clk_o    = data_clk_q;
   assign quarter_o     = quarter_q;
   assign data_tick_o   = tick_q;
   assign stretching_o  = stretch_q;
   assign timeout_err_o = terr_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2c_clk_gen.sv
// Directed bench for i2c_clk_gen: DIVIDER=4, CHK_OFS=3, STRETCH_TIMEOUT=8.
// Pad model drives scl_in = !scl_oe unless the slave forces SCL low.
module tb_i2c_clk_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       clear_err;
   logic       scl_force;
   logic       scl_in;
   logic       scl_oe;
   logic       data_clk;
   logic [1:0] quarter;
   logic       data_tick;
   logic       stretching;
   logic       timeout_err;
   logic       busy;

   int   nvec = 0;
   int   nerr = 0;
   logic e_terr = 1'b0;

   always #5 clk = ~clk;

   assign scl_in = scl_force ? 1'b0 : !scl_oe;

   i2c_clk_gen #(
      .DIVIDER(4),
      .CNT_W(4),
      .CHK_OFS(3),
      .TO_W(4),
      .STRETCH_TIMEOUT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena_i(ena),
      .scl_in_i(scl_in),
      .clear_err_i(clear_err),
      .scl_oe_o(scl_oe),
      .data_clk_o(data_clk),
      .quarter_o(quarter),
      .data_tick_o(data_tick),
      .stretching_o(stretching),
      .timeout_err_o(timeout_err),
      .busy_o(busy)
   );

   // {busy, scl_oe, data_clk, quarter, data_tick, stretching, timeout_err}
   function automatic logic [7:0] ev(input int c, input logic st,
                                     input logic te, input logic b);
      logic [1:0] q;
      if (!b) return {7'b0, te};
      q = 2'(c / 4);
      return {1'b1, c < 8, (c >= 4) && (c < 12), q, c == 4, st, te};
   endfunction

   task automatic chk(input string tag, input int c, input logic st,
                      input logic b);
      logic [7:0] obs;
      logic [7:0] exp;
      @(negedge clk);
      obs = {busy, scl_oe, data_clk, quarter, data_tick, stretching,
             timeout_err};
      exp = ev(c, st, e_terr, b);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s cnt=%0d observed=%b expected=%b", tag, c, obs, exp);
      end
   endtask

   task automatic walk(input string tag, input int from, input int upto);
      for (int i = from; i <= upto; i++) chk(tag, i, 1'b0, 1'b1);
   endtask

   task automatic hold11(input string tag, input int n);
      chk(tag, 11, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) chk(tag, 11, 1'b1, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      ena       = 1'b0;
      clear_err = 1'b0;
      scl_force = 1'b0;
      chk("reset", 0, 1'b0, 1'b0);
      chk("reset", 0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("idle_noena", 0, 1'b0, 1'b0);
      ena = 1'b1;

      walk("freerun", 0, 15);
      walk("freerun", 0, 15);

      walk("stretch5", 0, 10);
      chk("stretch5", 11, 1'b0, 1'b1);
      scl_force = 1'b1;
      for (int i = 0; i < 5; i++) chk("stretch5", 11, 1'b1, 1'b1);
      scl_force = 1'b0;
      walk("stretch5", 12, 15);
      walk("after_stretch", 0, 15);

      scl_force = 1'b1;
      walk("timeout_a", 0, 10);
      hold11("timeout_a", 8);
      e_terr = 1'b1;
      walk("timeout_a", 12, 15);

      walk("timeout_b", 0, 10);
      hold11("timeout_b", 8);
      clear_err = 1'b1;
      chk("set_wins", 12, 1'b0, 1'b1);
      clear_err = 1'b0;
      walk("timeout_b", 13, 15);

      walk("clear_err", 0, 2);
      clear_err = 1'b1;
      e_terr = 1'b0;
      chk("clear_err", 3, 1'b0, 1'b1);
      clear_err = 1'b0;
      walk("timeout_c", 4, 10);
      hold11("timeout_c", 8);
      e_terr = 1'b1;
      walk("timeout_c", 12, 15);
      scl_force = 1'b0;

      walk("ena_drop", 0, 5);
      ena = 1'b0;
      walk("ena_drop", 6, 15);
      chk("idle", 0, 1'b0, 1'b0);
      chk("idle", 0, 1'b0, 1'b0);
      chk("idle", 0, 1'b0, 1'b0);
      ena = 1'b1;
      walk("restart", 0, 15);

      scl_force = 1'b1;
      walk("rst_stretch", 0, 10);
      hold11("rst_stretch", 2);
      rst = 1'b1;
      e_terr = 1'b0;
      chk("rst_abort", 0, 1'b0, 1'b0);
      scl_force = 1'b0;
      chk("rst_abort", 0, 1'b0, 1'b0);
      rst = 1'b0;
      walk("post_rst", 0, 15);
      walk("post_rst", 0, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
